// File: rtl/uart_bus_ctrl.sv
// ---------------------------------------------------------------------------
// uart_bus_ctrl
// Bus-side controller for a UART rx/tx datapath. It is an AHB-lite subset
// slave with a TX FIFO feeding a one-byte-at-a-time transmit sequencer, and
// an RX FIFO that collects bytes from the receiver and is popped by CPU reads.
//
// Optional feature macro: UART_CTRL_IRQ_EN
//    defined   : IRQ_MASK register (0xC, bits[1:0]) is read/write and irq_o
//                is a registered, maskable interrupt.
//    undefined : irq_o is tied low, IRQ_MASK reads 0 and ignores writes.
//
// Ports
//    clk_i          system clock
//    rst_i          asynchronous active-high reset
//    hSel_i         slave select
//    hTrans_i[1:0]  transfer type, bit1 = valid transfer
//    hWrite_i       1 = write
//    hAddr_i[3:0]   byte address, bits[3:2] select the register
//    hWData_i[31:0] write data (data phase)
//    hRData_o[31:0] read data (data phase)
//    hReady_o       0 = wait state (stalled DATA write on a full TX FIFO)
//    data_tx_o[7:0] byte presented to the transmitter
//    tx_en_o        one-cycle start pulse to the transmitter
//    tx_complete_i  transmitter finished the current byte
//    data_rx_i[7:0] byte from the receiver
//    rx_flag_i      one-cycle pulse, data_rx_i valid
//    irq_o          interrupt
//
// Register map (word offsets)
//    0x0 DATA     W: push TX FIFO    R: pop RX FIFO (0 when empty)
//    0x4 STATUS   [0] rx_nonempty [1] tx_full [2] tx_empty_and_idle [3] rx_ovr
//    0x8 CLEAR    W: bit3 = 1 clears rx_ovr, reads 0
//    0xC IRQ_MASK [1:0] (only with UART_CTRL_IRQ_EN)
//
// TX sequencer states
//    state  | meaning
//    S_IDLE | waiting for a byte; head is copied to data_tx_o when non-empty
//    S_LOAD | tx_en_o high for one cycle, FIFO head popped
//    S_WAIT | holding data_tx_o until tx_complete_i
// ---------------------------------------------------------------------------
module uart_bus_ctrl #(
   parameter int TX_DEPTH = 4,
   parameter int RX_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        hSel_i,
   input  logic [1:0]  hTrans_i,
   input  logic        hWrite_i,
   input  logic [3:0]  hAddr_i,
   input  logic [31:0] hWData_i,
   output logic [31:0] hRData_o,
   output logic        hReady_o,
   output logic [7:0]  data_tx_o,
   output logic        tx_en_o,
   input  logic        tx_complete_i,
   input  logic [7:0]  data_rx_i,
   input  logic        rx_flag_i,
   output logic        irq_o
);

   localparam int TXAW = $clog2(TX_DEPTH);
   localparam int RXAW = $clog2(RX_DEPTH);
   localparam logic [TXAW:0] TX_FULL_CNT = (TXAW+1)'(TX_DEPTH);
   localparam logic [RXAW:0] RX_FULL_CNT = (RXAW+1)'(RX_DEPTH);

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CLEAR  = 2'd2;
   localparam logic [1:0] REG_MASK   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2
   } tx_state_e;

   tx_state_e state_q, state_d;

   // bus pipeline
   logic        valid_q;
   logic        write_q;
   logic [1:0]  addr_q;
   logic [31:0] rdata_q, rdata_d;

   // TX FIFO
   logic [7:0]      tx_mem_q [TX_DEPTH];
   logic [TXAW-1:0] tx_wp_q, tx_rp_q;
   logic [TXAW:0]   tx_cnt_q;

   // RX FIFO
   logic [7:0]      rx_mem_q [RX_DEPTH];
   logic [RXAW-1:0] rx_wp_q, rx_rp_q;
   logic [RXAW:0]   rx_cnt_q;

   logic [7:0] data_tx_q;
   logic       rx_ovr_q;
   logic [1:0] mask_rd;

   logic accept, wr_data, hready;
   logic tx_wr, tx_push, tx_pop, tx_load, tx_en;
   logic tx_full, tx_empty, tx_idle_empty;
   logic rx_pop, rx_push, rx_full, rx_nonempty;
   logic ovr_set, ovr_clr;
   logic [3:0] status;
   logic unused_ok;

   assign unused_ok = ^{hWData_i[31:8], hTrans_i[0], hAddr_i[1:0]};

   // ------------------------------------------------------------------
   // Flags and handshakes
   // ------------------------------------------------------------------
   assign tx_full       = (tx_cnt_q == TX_FULL_CNT);
   assign tx_empty      = (tx_cnt_q == '0);
   assign tx_idle_empty = tx_empty & (state_q == S_IDLE);
   assign rx_full       = (rx_cnt_q == RX_FULL_CNT);
   assign rx_nonempty   = (rx_cnt_q != '0);

   assign status = {rx_ovr_q, tx_idle_empty, tx_full, rx_nonempty};

   assign accept  = hSel_i & hTrans_i[1] & hready;
   assign wr_data = valid_q & write_q;

   // A sequencer pop in the same cycle frees the slot, so a write to a
   // full FIFO completes without waiting for the count to drop.
   assign tx_wr   = wr_data & (addr_q == REG_DATA);
   assign tx_push = tx_wr & (~tx_full | tx_pop);
   assign hready  = ~(tx_wr & tx_full & ~tx_pop);

   assign rx_pop  = accept & ~hWrite_i & (hAddr_i[3:2] == REG_DATA) & rx_nonempty;
   assign rx_push = rx_flag_i & (~rx_full | rx_pop);
   assign ovr_set = rx_flag_i & rx_full & ~rx_pop;
   assign ovr_clr = wr_data & (addr_q == REG_CLEAR) & hWData_i[3];

   assign hReady_o  = hready;
   assign hRData_o  = rdata_q;
   assign data_tx_o = data_tx_q;
   assign tx_en_o   = tx_en;

   // ------------------------------------------------------------------
   // Bus pipeline: address phase registered, read data captured at the
   // end of the address phase
   // ------------------------------------------------------------------
   always_comb begin
      rdata_d = rdata_q;
      if (accept) begin
         rdata_d = '0;
         if (!hWrite_i) begin
            case (hAddr_i[3:2])
               REG_DATA:   if (rx_nonempty) rdata_d = {24'b0, rx_mem_q[rx_rp_q]};
               REG_STATUS: rdata_d = {28'b0, status};
               REG_MASK:   rdata_d = {30'b0, mask_rd};
               default:    rdata_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         write_q <= 1'b0;
         addr_q  <= 2'b00;
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
         if (hready) begin
            valid_q <= accept;
            write_q <= hWrite_i;
            addr_q  <= hAddr_i[3:2];
         end
      end
   end

   // ------------------------------------------------------------------
   // TX FIFO
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem_q[tx_wp_q] <= hWData_i[7:0];
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
      end else begin
         if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
         if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
         case ({tx_push, tx_pop})
            2'b10:   tx_cnt_q <= tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_q <= tx_cnt_q - 1'b1;
            default: tx_cnt_q <= tx_cnt_q;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // RX FIFO and overflow flag
   // ------------------------------------------------------------------
   // On a full FIFO with a same-cycle pop, wp == rp: the read above sees
   // the old head before this write replaces that slot.
   always_ff @(posedge clk_i) begin
      if (rx_push) rx_mem_q[rx_wp_q] <= data_rx_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
         rx_ovr_q <= 1'b0;
      end else begin
         if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
         if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
         case ({rx_push, rx_pop})
            2'b10:   rx_cnt_q <= rx_cnt_q + 1'b1;
            2'b01:   rx_cnt_q <= rx_cnt_q - 1'b1;
            default: rx_cnt_q <= rx_cnt_q;
         endcase
         if (ovr_set)      rx_ovr_q <= 1'b1;
         else if (ovr_clr) rx_ovr_q <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // TX sequencer
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (!tx_empty) state_d = S_LOAD;
         S_LOAD:  state_d = S_WAIT;
         S_WAIT:  if (tx_complete_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // The head is captured while leaving IDLE so data_tx_o is already valid
   // during the tx_en_o pulse; the pop in LOAD then only advances rp.
   always_comb begin
      tx_en   = 1'b0;
      tx_pop  = 1'b0;
      tx_load = 1'b0;
      case (state_q)
         S_IDLE:  tx_load = ~tx_empty;
         S_LOAD:  begin
            tx_en  = 1'b1;
            tx_pop = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)        data_tx_q <= 8'h00;
      else if (tx_load) data_tx_q <= tx_mem_q[tx_rp_q];
   end

   // ------------------------------------------------------------------
   // Interrupt
   // ------------------------------------------------------------------
`ifdef UART_CTRL_IRQ_EN
   logic [1:0] mask_q;
   logic       irq_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mask_q <= 2'b00;
         irq_q  <= 1'b0;
      end else begin
         if (wr_data && (addr_q == REG_MASK)) mask_q <= hWData_i[1:0];
         irq_q <= (mask_q[0] & rx_nonempty) | (mask_q[1] & tx_idle_empty);
      end
   end

   assign mask_rd = mask_q;
   assign irq_o   = irq_q;
`else
   assign mask_rd = 2'b00;
   assign irq_o   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_bus_ctrl.sv
module tb_uart_bus_ctrl;

   localparam int TXD = 4;
   localparam int RXD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        hSel;
   logic [1:0]  hTrans;
   logic        hWrite;
   logic [3:0]  hAddr;
   logic [31:0] hWData;
   logic [31:0] hRData;
   logic        hReady;
   logic [7:0]  data_tx;
   logic        tx_en;
   logic        tx_complete;
   logic [7:0]  data_rx;
   logic        rx_flag;
   logic        irq;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] txmon[$];
   int         txmon_cyc[$];
   int         ncyc = 0;

   always #5 clk = ~clk;

   uart_bus_ctrl #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
      .clk_i(clk), .rst_i(rst), .hSel_i(hSel), .hTrans_i(hTrans),
      .hWrite_i(hWrite), .hAddr_i(hAddr), .hWData_i(hWData),
      .hRData_o(hRData), .hReady_o(hReady), .data_tx_o(data_tx),
      .tx_en_o(tx_en), .tx_complete_i(tx_complete), .data_rx_i(data_rx),
      .rx_flag_i(rx_flag), .irq_o(irq)
   );

   // transmitter-side monitor: every start pulse with its byte and cycle
   initial forever begin
      @(negedge clk);
      ncyc++;
      if (tx_en === 1'b1) begin
         txmon.push_back(data_tx);
         txmon_cyc.push_back(ncyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic idle_bus();
      hSel   = 1'b0;
      hTrans = 2'b00;
      hWrite = 1'b0;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      int w;
      hSel = 1'b1; hTrans = 2'b10; hWrite = 1'b1; hAddr = a;
      tick();
      idle_bus();
      hWData = d;
      w = 0;
      while (hReady !== 1'b1 && w < 50) begin
         tick();
         w++;
      end
      if (w >= 50) check("write_stall_timeout", 32'(hReady), 32'd1);
      tick();
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
      hSel = 1'b1; hTrans = 2'b10; hWrite = 1'b0; hAddr = a;
      tick();
      idle_bus();
      @(negedge clk);
      d = hRData;
      @(posedge clk);
      #1;
   endtask

   task automatic rx_inject(input logic [7:0] b);
      data_rx = b;
      rx_flag = 1'b1;
      tick();
      rx_flag = 1'b0;
   endtask

   task automatic complete_pulse();
      tx_complete = 1'b1;
      tick();
      tx_complete = 1'b0;
   endtask

   task automatic wait_tx(input int n);
      int w;
      w = 0;
      while (txmon.size() < n && w < 50) begin
         tick();
         w++;
      end
      if (w >= 50) check("tx_start_timeout", 32'(txmon.size()), 32'(n));
   endtask

   logic [31:0] d;
   logic [31:0] wd;
   logic [7:0]  b;
   logic [7:0]  wq[$];
   logic [7:0]  rxq[$];
   logic [7:0]  eb;
   int          pending;
   logic        ovr;
   int          comp_n;
   logic        seen;

   initial begin
      rst = 1'b1; idle_bus(); hAddr = 4'h0; hWData = '0;
      tx_complete = 1'b0; data_rx = 8'h00; rx_flag = 1'b0;

      // ---- reset state
      @(negedge clk);
      check("rst_hrdata", hRData, 32'h0);
      check("rst_hready", 32'(hReady), 32'd1);
      check("rst_tx_en", 32'(tx_en), 32'd0);
      check("rst_data_tx", 32'(data_tx), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      tick();
      bus_read(4'h4, d);
      check("rst_status", d, 32'h04);

      // ---- single byte transmit
      bus_write(4'h0, 32'h55);
      @(negedge clk); check("tx_en_early", 32'(tx_en), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); check("tx_en_pulse", 32'(tx_en), 32'd1);
      check("tx_data_55", 32'(data_tx), 32'h55);
      @(posedge clk); #1;
      @(negedge clk); check("tx_en_one_cycle", 32'(tx_en), 32'd0);
      check("tx_data_hold", 32'(data_tx), 32'h55);
      @(posedge clk); #1;
      idle(8);
      complete_pulse();
      idle(2);
      bus_read(4'h4, d);
      check("status_after_tx", d, 32'h04);
      check("tx_count_single", 32'(txmon.size()), 32'd1);

      // ---- 6-byte burst with stall on the full FIFO
      txmon.delete(); txmon_cyc.delete();
      for (int i = 1; i <= 6; i++) begin
         hSel = 1'b1; hTrans = 2'b10; hWrite = 1'b1; hAddr = 4'h0;
         if (i > 1) hWData = 32'(i - 1);
         @(negedge clk);
         check($sformatf("burst_ready_%0d", i), 32'(hReady), 32'd1);
         @(posedge clk); #1;
      end
      idle_bus();
      hWData = 32'h6;
      @(negedge clk); check("burst_stall", 32'(hReady), 32'd0);
      repeat (4) begin
         @(posedge clk); #1;
      end
      @(negedge clk); check("burst_stall_held", 32'(hReady), 32'd0);
      check("burst_one_started", 32'(txmon.size()), 32'd1);
      @(posedge clk); #1;
      tx_complete = 1'b1;
      comp_n = ncyc + 1;
      @(negedge clk); check("stall_on_complete", 32'(hReady), 32'd0);
      @(posedge clk); #1;
      tx_complete = 1'b0;
      @(negedge clk); check("stall_in_idle", 32'(hReady), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); check("stall_release", 32'(hReady), 32'd1);
      @(posedge clk); #1;
      hWData = '0;
      for (int k = 2; k <= 6; k++) begin
         wait_tx(k);
         idle(2);
         complete_pulse();
      end
      idle(3);
      check("burst_gap", 32'(txmon_cyc.size() > 1 ? txmon_cyc[1] - comp_n : -1), 32'd2);
      check("burst_count", 32'(txmon.size()), 32'd6);
      for (int i = 0; i < txmon.size(); i++)
         check($sformatf("burst_order_%0d", i), 32'(txmon[i]), 32'(i + 1));
      bus_read(4'h4, d);
      check("status_after_burst", d, 32'h04);

      // ---- RX overflow
      for (int i = 0; i < 5; i++) rx_inject(8'hA0 + 8'(i));
      bus_read(4'h4, d);
      check("status_ovr", d, 32'h0D);
      for (int i = 0; i < 4; i++) begin
         bus_read(4'h0, d);
         check($sformatf("rx_read_%0d", i), d, 32'hA0 + 32'(i));
      end
      bus_read(4'h0, d);
      check("rx_read_empty", d, 32'h0);
      bus_read(4'h4, d);
      check("status_ovr_empty", d, 32'h0C);
      bus_write(4'h8, 32'h8);
      bus_read(4'h4, d);
      check("status_ovr_cleared", d, 32'h04);
      bus_read(4'h8, d);
      check("clear_reads_0", d, 32'h0);

      // ---- RX push on a full FIFO with a same-cycle pop
      for (int i = 1; i <= 4; i++) rx_inject(8'hB0 + 8'(i));
      hSel = 1'b1; hTrans = 2'b10; hWrite = 1'b0; hAddr = 4'h0;
      data_rx = 8'hB5; rx_flag = 1'b1;
      tick();
      idle_bus(); rx_flag = 1'b0;
      @(negedge clk); d = hRData;
      check("rx_simul_head", d, 32'hB1);
      @(posedge clk); #1;
      bus_read(4'h4, d);
      check("status_no_ovr", d, 32'h05);
      for (int i = 2; i <= 5; i++) begin
         bus_read(4'h0, d);
         check($sformatf("rx_simul_read_%0d", i), d, 32'hB0 + 32'(i));
      end
      bus_read(4'h0, d);
      check("rx_simul_empty", d, 32'h0);

      // ---- interrupt
`ifdef UART_CTRL_IRQ_EN
      bus_write(4'hC, 32'h1);
      bus_read(4'hC, d);
      check("irq_mask_rb", d, 32'h1);
      rx_inject(8'h3C);
      @(negedge clk); check("irq_not_yet", 32'(irq), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); check("irq_set", 32'(irq), 32'd1);
      @(posedge clk); #1;
      bus_read(4'h0, d);
      check("irq_rx_byte", d, 32'h3C);
      @(negedge clk); check("irq_cleared", 32'(irq), 32'd0);
      @(posedge clk); #1;
      bus_write(4'hC, 32'h0);
`else
      bus_write(4'hC, 32'h1);
      bus_read(4'hC, d);
      check("irq_mask_reads_0", d, 32'h0);
      rx_inject(8'h3C);
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (irq !== 1'b0) seen = 1'b1;
      end
      @(posedge clk); #1;
      check("irq_stays_0", 32'(seen), 32'd0);
      bus_read(4'h0, d);
      check("irq_rx_byte", d, 32'h3C);
`endif

      // ---- reset in the middle of a transfer
      bus_write(4'h0, 32'h77);
      bus_write(4'h0, 32'h78);
      rx_inject(8'h99);
      idle(3);
      rst = 1'b1;
      #1;
      check("midrst_tx_en", 32'(tx_en), 32'd0);
      check("midrst_data_tx", 32'(data_tx), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      txmon.delete(); txmon_cyc.delete();
      bus_read(4'h4, d);
      check("midrst_status", d, 32'h04);
      bus_read(4'h0, d);
      check("midrst_rx_discarded", d, 32'h0);
      idle(6);
      check("midrst_no_tx", 32'(txmon.size()), 32'd0);

      // ---- randomized operations against a queue model
      wq.delete(); rxq.delete();
      pending = 0; ovr = 1'b0;
      for (int it = 0; it < 200; it++) begin
         case ($urandom_range(0, 5))
            0: if (pending <= TXD) begin
                  wd = $urandom;
                  bus_write(4'h0, wd);
                  wq.push_back(wd[7:0]);
                  pending++;
               end
            1: begin
                  bus_read(4'h0, d);
                  eb = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
                  check("rand_rx_data", d, {24'b0, eb});
               end
            2: begin
                  bus_read(4'h4, d);
                  check("rand_status", d, {28'b0, ovr, pending == 0,
                                           pending == TXD + 1, rxq.size() != 0});
               end
            3: begin
                  b = 8'($urandom);
                  rx_inject(b);
                  if (rxq.size() < RXD) rxq.push_back(b);
                  else ovr = 1'b1;
               end
            4: if (pending > 0) begin
                  complete_pulse();
                  pending--;
               end
            default: begin
                  wd = $urandom;
                  bus_write(4'h8, wd);
                  if (wd[3]) ovr = 1'b0;
               end
         endcase
         idle(3);
      end
      while (pending > 0) begin
         complete_pulse();
         pending--;
         idle(3);
      end
      check("rand_tx_count", 32'(txmon.size()), 32'(wq.size()));
      for (int i = 0; i < txmon.size() && i < wq.size(); i++)
         check($sformatf("rand_tx_order_%0d", i), 32'(txmon[i]), 32'(wq[i]));
      bus_read(4'h4, d);
      check("rand_final_status", d, {28'b0, ovr, 1'b1, 1'b0, rxq.size() != 0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_bus_ctrl.md
Name: uart_bus_ctrl

Overview:
Bus-side controller for the UART rx/tx datapath, acting as an AHB-lite subset slave. CPU writes bytes into a TX FIFO, and a sequencer hands them one at a time to the UART transmitter. Bytes flagged by the UART receiver are captured into an RX FIFO and popped by CPU reads. Status is reported through a register, and write stalls are signalled with hReady_o.

Parameters:
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
RX_DEPTH, 4, RX FIFO entries (power of 2, >=2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
hSel_i  in  1  slave select
hTrans_i  in  2  transfer type; bit1=1 means NONSEQ/SEQ (valid)
hWrite_i  in  1  1=write
hAddr_i  in  4  byte address; bits[3:2] select register
hWData_i  in  32  write data (data phase)
hRData_o  out  32  read data (data phase)
hReady_o  out  1  0 = wait state
data_tx_o  out  8  byte to UART transmitter
tx_en_o  out  1  one-cycle start pulse to transmitter
tx_complete_i  in  1  transmitter finished current byte (pulse or level)
data_rx_i  in  8  byte from UART receiver
rx_flag_i  in  1  one-cycle pulse: data_rx_i valid
irq_o  out  1  interrupt (see Optional Feature)

Behaviour:
- Reset (async, rst_i=1): both FIFOs empty, all pointers and counts 0, TX FSM=IDLE, hRData_o=0, hReady_o=1, data_tx_o=0, tx_en_o=0, RX_OVR=0, irq_o=0.
- Address phase is accepted when hSel_i & hTrans_i[1] & hReady_o. Address and direction are registered; the data phase is the next cycle.
- Register map (word offsets):
  - 0x0 DATA: write pushes hWData_i[7:0] into the TX FIFO; read pops the RX FIFO.
  - 0x4 STATUS (RO): [0] rx_nonempty, [1] tx_full, [2] tx_empty_and_idle, [3] RX_OVR, [7:4] reserved 0.
  - 0x8 CLEAR: write 1 to bit3 clears RX_OVR; reads return 0.
  - 0xC IRQ_MASK.
- DATA write with TX FIFO not full: push in the data-phase cycle, no wait state.
- DATA write with TX FIFO full: hReady_o=0 until a slot frees (the sequencer pop). The push happens in the cycle hReady_o returns to 1. hWData_i is held by the master.
- DATA read: hRData_o={24'b0, RX head}, registered at the end of the address phase and valid in the data phase. The pop occurs at address-phase acceptance. Reading an empty FIFO returns 0 with no pop and no stall.
- Reads have zero wait states. Unmapped bits read 0.
- TX sequencer FSM:
  - IDLE: if TX FIFO non-empty -> LOAD.
  - LOAD: data_tx_o<=head, tx_en_o=1 for exactly 1 cycle, pop -> WAIT.
  - WAIT: hold data_tx_o; on tx_complete_i=1 -> IDLE.
  - tx_complete_i is ignored outside WAIT.
  - Back-to-back bytes: minimum 2 cycles from tx_complete_i to the next tx_en_o.
- RX capture: on rx_flag_i, push data_rx_i if RX FIFO not full. If full, drop the byte and set RX_OVR (sticky).
- RX simultaneous push and pop on a full or empty FIFO: count stays correct. If the FIFO is full, a same-cycle pop frees a slot, so the byte is accepted with no overflow.
- TX simultaneous CPU push and sequencer pop: handled the same way. A stalled write completes in that same cycle.
- Pointers wrap modulo depth; counts are log2(DEPTH)+1 bits wide.
- Reset mid-transfer: FSM is forced to IDLE, tx_en_o=0, and FIFO contents are discarded.

Optional Feature:
- Macro UART_CTRL_IRQ_EN.
- Defined:
  - IRQ_MASK register (0xC, bits[1:0], reset 0) is read/write.
  - irq_o = (mask[0] & rx_nonempty) | (mask[1] & tx_empty_and_idle), registered, 1-cycle delay.
- Undefined:
  - irq_o tied 0.
  - IRQ_MASK reads 0 and writes are ignored.

Test Plan:
- Reset, then read STATUS -> 0x04 (tx_empty_and_idle=1); hRData_o=0, hReady_o=1, tx_en_o=0.
- Write 0x55 to DATA -> 2 cycles later tx_en_o pulses 1 cycle with data_tx_o=0x55. Pulse tx_complete_i 10 cycles later -> FSM IDLE, STATUS=0x04.
- Write 6 bytes (0x01..0x06) back-to-back with tx_complete_i held 0 -> the first is popped to the sequencer, 4 fill the FIFO, and the 6th sees hReady_o=0. It is released the cycle after the next tx_complete_i and pop. Bytes are transmitted in order 0x01..0x06.
- Pulse rx_flag_i 5 times with 0xA0..0xA4, no reads -> STATUS bit3=1. Reads return 0xA0..0xA3, then the 5th read returns 0. Writing 0x8 to CLEAR clears RX_OVR.
- RX FIFO full, and rx_flag_i (0xB5) occurs in the same cycle as a DATA read address phase -> 0xB5 is accepted, RX_OVR stays 0.
- With UART_CTRL_IRQ_EN defined: mask=0x1, inject rx byte 0x3C -> irq_o=1 one cycle later; read DATA -> irq_o=0. Without the macro -> irq_o stays 0.
